// File: rtl/pool_ctrl.sv
// pool_ctrl: sequencer that walks a feature map in non-overlapping 2x2
// windows, fetches each window from a synchronous-read input RAM, hands it
// to the 2x2 max-pool unit and writes the pooled pixel to an output RAM.
// The row stride is the full map width as given at start, so an odd width
// or height simply drops the last column/row without disturbing the layout.
module pool_ctrl #(
  parameter int AW   = 12,
  parameter int DW   = 8,
  parameter int DIMW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [DIMW-1:0] cfg_w,
  input  logic [DIMW-1:0] cfg_h,
  input  logic [AW-1:0]   in_base,
  input  logic [AW-1:0]   out_base,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [DW-1:0]   rd_data,
  output logic [DW-1:0]   pool_din1,
  output logic [DW-1:0]   pool_din2,
  output logic [DW-1:0]   pool_din3,
  output logic [DW-1:0]   pool_din4,
  output logic            pool_en,
  output logic            pool_rst,
  input  logic [DW-1:0]   pool_dout,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic            busy,
  output logic            done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] POOL  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [1:0]      k;
  logic [DIMW-1:0] stride;
  logic [DIMW-1:0] w_even;
  logic [DIMW-1:0] h_even;
  logic [DIMW-1:0] col;
  logic [DIMW-1:0] row;
  logic [AW-1:0]   rowptr;
  logic [AW-1:0]   optr;

  logic [DIMW-1:0] cfg_w_even;
  logic [DIMW-1:0] cfg_h_even;
  logic            dims_ok;
  logic            accept;
  logic [AW-1:0]   stride_a;
  logic [AW-1:0]   win_addr;
  logic [DIMW-1:0] col_nxt;
  logic [DIMW-1:0] row_nxt;
  logic            row_end;
  logic            last_window;

  assign cfg_w_even  = cfg_w & ~DIMW'(1);
  assign cfg_h_even  = cfg_h & ~DIMW'(1);
  assign dims_ok     = (cfg_w_even >= DIMW'(2)) && (cfg_h_even >= DIMW'(2));
  assign accept      = (state == IDLE) && start && !abort;
  assign stride_a    = AW'(stride);
  assign win_addr    = rowptr + AW'(col);
  assign col_nxt     = col + DIMW'(2);
  assign row_nxt     = row + DIMW'(2);
  assign row_end     = (col_nxt == w_even);
  assign last_window = row_end && (row_nxt == h_even);

  // Next-state selection; abort pulls every active state back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = dims_ok ? FETCH : DONE;
      FETCH:   if (k == 2'd3) state_nxt = WAIT;
      WAIT:    state_nxt = POOL;
      POOL:    state_nxt = WRITE;
      WRITE:   state_nxt = last_window ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  // State, latched configuration and scan position (row/col/pointers)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= 2'd0;
      stride <= '0;
      w_even <= '0;
      h_even <= '0;
      col    <= '0;
      row    <= '0;
      rowptr <= '0;
      optr   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            stride <= cfg_w;
            w_even <= cfg_w_even;
            h_even <= cfg_h_even;
            rowptr <= in_base;
            optr   <= out_base;
            col    <= '0;
            row    <= '0;
            k      <= 2'd0;
          end
        end
        FETCH: begin
          k <= k + 2'd1;
        end
        WRITE: begin
          optr <= optr + AW'(1);
          k    <= 2'd0;
          if (row_end) begin
            col    <= '0;
            row    <= row_nxt;
            rowptr <= rowptr + stride_a + stride_a;
          end else begin
            col <= col_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Window pixel capture: each read lands one cycle after its strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_din1 <= '0;
      pool_din2 <= '0;
      pool_din3 <= '0;
      pool_din4 <= '0;
    end else begin
      case (state)
        FETCH: begin
          case (k)
            2'd1:    pool_din1 <= rd_data;
            2'd2:    pool_din2 <= rd_data;
            2'd3:    pool_din3 <= rd_data;
            default: begin
            end
          endcase
        end
        WAIT: begin
          pool_din4 <= rd_data;
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes and addresses decoded from the current state
  always_comb begin
    rd_en    = 1'b0;
    rd_addr  = '0;
    pool_en  = 1'b0;
    pool_rst = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    busy     = (state != IDLE);
    done     = 1'b0;
    case (state)
      IDLE: begin
        pool_rst = start && !abort && !rst;
      end
      FETCH: begin
        rd_en = 1'b1;
        case (k)
          2'd0:    rd_addr = win_addr;
          2'd1:    rd_addr = win_addr + AW'(1);
          2'd2:    rd_addr = win_addr + stride_a;
          default: rd_addr = win_addr + stride_a + AW'(1);
        endcase
      end
      POOL: begin
        pool_en = 1'b1;
      end
      WRITE: begin
        wr_en   = !abort;
        wr_addr = optr;
        wr_data = pool_dout;
      end
      DONE: begin
        done = !abort;
      end
      default: begin
      end
    endcase
  end

endmodule
